tohost_axi_snoop: RTL
=====================

Name: tohost_axi_snoop

Overview:
- Passive monitor on the LEVE1 data-side AXI write channels (AW/W/B) between the core and TB_RAM.
- Detects a completed write to the tohost word and produces the tohost_we/tohost pair that the testbench uses to report pass/fail and call $finish.
- Also provides a cycle watchdog, so a hung core still terminates the simulation with a fail code.
- Never drives any AXI signal.

Parameters:
- ADDR_W, 32, AXI address width
- ID_W, 4, AXI ID width
- TOHOST_ADDR, 32'h8000_1000, byte address of the tohost word (4-byte aligned)
- TIMEOUT, 0, watchdog limit in cycles; 0 disables the watchdog
- QDEPTH, 4, depth of the AW queue and of the B-pending queue (power of 2)

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset
- AWVALID  in  1  write address valid
- AWREADY  in  1  write address ready
- AWADDR  in  ADDR_W  burst start address
- AWLEN  in  8  beats minus 1
- AWID  in  ID_W  write ID
- WVALID  in  1  write data valid
- WREADY  in  1  write data ready
- WDATA  in  32  write data
- WSTRB  in  4  byte strobes
- WLAST  in  1  last beat
- BVALID  in  1  response valid
- BREADY  in  1  response ready
- BID  in  ID_W  response ID
- BRESP  in  2  response code
- tohost_we  out  1  one-cycle pulse: tohost is valid
- tohost  out  32  exit code
- timeout_hit  out  1  sticky: watchdog fired
- err  out  1  sticky: protocol violation seen by the monitor

Behaviour:
- Reset is RSTn, asynchronous, active-low; clock is CLK. All registers are reset by it.
- Reset values: tohost_we=0, tohost=0, timeout_hit=0, err=0, queues empty, beat counter 0, state RUN.
- Handshakes: a handshake occurs when VALID&READY is high on a rising CLK edge.
- AW queue:
  - Each AW handshake pushes {AWID, AWADDR[ADDR_W-1:2], AWLEN}.
  - Push when full: the entry is dropped and err is set.
- W tracking:
  - Each W beat is associated with the AW queue head. A same-cycle AW push is visible to the W logic (bypass).
  - A W handshake with no head and no same-cycle AW: err is set and the beat is ignored. LEVE1 never issues W before AW.
  - Beat word address = head word address + beat counter (INCR bursts only; 32-bit words).
  - On an address match with TOHOST_ADDR[ADDR_W-1:2]: merge WDATA into the per-burst hold register byte-wise by WSTRB, and set hit. The hold register is cleared at burst start.
  - Beat counter increments per beat.
  - On WLAST: pop the head and push {id, hit, hold} to the B-pending queue; the beat counter returns to 0.
  - WLAST on a beat count other than len, or beat count exceeding len without WLAST: err is set. Pop still occurs on WLAST.
  - B-pending queue full on push: err is set and the entry is dropped.
- B handling:
  - TB_RAM responds in order.
  - A B handshake pops the B-pending head. If the queue is empty, or BID is not equal to the head id, err is set and nothing is popped.
  - If the popped entry has hit=1 and BRESP==2'b00: tohost is loaded with hold and tohost_we=1 on the next cycle for exactly one cycle. State goes to DONE.
  - If hit=1 and BRESP!=0: err is set and no tohost_we pulse occurs.
- Same-cycle events: AW push, W pop and B pop in one cycle are all legal. Occupancy changes by push minus pop; a push into a full queue that is simultaneously popped is not an overflow.
- Watchdog:
  - A 32-bit cycle counter runs from reset release while in state RUN.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1: tohost=32'hFFFF_FFFF, tohost_we pulses for one cycle, timeout_hit=1, state goes to DONE.
  - If a tohost hit and the watchdog fire in the same cycle, the tohost hit wins.
- DONE: no further tohost_we pulses. The monitor keeps tracking and err detection stays active. tohost holds its value.
- Reset mid-burst: all state is discarded and queues are emptied. Beats of the interrupted burst after release are flagged per the rules above.

Test Plan:
- Single write, AWADDR=TOHOST_ADDR, AWLEN=0, WDATA=32'h1, WSTRB=4'hF, BRESP=0 -> tohost_we high exactly one cycle after the B handshake, tohost=32'h0000_0001, err=0.
- Write to TOHOST_ADDR+4 with data 1 -> no tohost_we. Then a write to TOHOST_ADDR with 32'h0000_0007 -> tohost=7. A second later hit -> no pulse (DONE).
- 4-beat burst at TOHOST_ADDR-8, beat 2 carries 32'hAABB_CCDD with WSTRB=4'b0011 -> tohost=32'h0000_CCDD.
- Three back-to-back AW handshakes before any W, then in-order W/B, with the hit on the third burst -> only the third produces the pulse; queues return to empty.
- Hit write with BRESP=2'b10 -> no tohost_we, err=1. Separately, a W handshake with an empty AW queue -> err=1.
- TIMEOUT=100, no writes -> tohost_we at cycle 100 after reset release, tohost=32'hFFFF_FFFF, timeout_hit=1. Assert RSTn low mid-burst -> all outputs return to reset values.

Source files
------------

// File: rtl/tohost_axi_snoop_if.sv
// AXI write-channel bundle (AW/W/B) seen between the LEVE1 data side and TB_RAM.
// The snoop attaches through the monitor modport and never drives anything.
interface tohost_axi_snoop_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [ID_W-1:0]   AWID;
  logic              WVALID;
  logic              WREADY;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WSTRB, WLAST, BREADY,
    input  AWREADY, WREADY, BVALID, BID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WSTRB, WLAST, BREADY,
    output AWREADY, WREADY, BVALID, BID, BRESP
  );

  modport monitor (
    input AWVALID, AWREADY, AWADDR, AWLEN, AWID, WVALID, WREADY, WDATA, WSTRB, WLAST,
          BVALID, BREADY, BID, BRESP
  );
endinterface

// File: rtl/tohost_axi_snoop.sv
// Passive AXI write snoop: reports the exit code written to tohost as a one-cycle
// tohost_we pulse, with an optional cycle watchdog that reports 32'hFFFF_FFFF.
module tohost_axi_snoop #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       ID_W        = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int unsigned       TIMEOUT     = 0,
  parameter int unsigned       QDEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  tohost_axi_snoop_if.monitor   bus,
  output logic                  tohost_we,
  output logic [31:0]           tohost,
  output logic                  timeout_hit,
  output logic                  err
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned WA = ADDR_W - 2;

  localparam logic StRun  = 1'b0;
  localparam logic StDone = 1'b1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [WA-1:0]   waddr;
    logic [7:0]      len;
  } aw_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            hit;
    logic [31:0]     hold;
  } b_t;

  aw_t           aw_mem [QDEPTH];
  logic [PW-1:0] aw_wr_q, aw_rd_q;
  logic [CW-1:0] aw_cnt_q, aw_cnt_d;
  b_t            b_mem [QDEPTH];
  logic [PW-1:0] b_wr_q, b_rd_q;
  logic [CW-1:0] b_cnt_q, b_cnt_d;
  logic [7:0]    beat_q, beat_d;
  logic [31:0]   hold_q, hold_d;
  logic          hit_q, hit_d;
  logic          state_q, state_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   tohost_q, tohost_d;
  logic          timeout_q, timeout_d;
  logic          err_q, err_d;

  logic        aw_hs, aw_empty, aw_full, aw_push, aw_pop, aw_ovf;
  aw_t         aw_new, head;
  logic        head_valid, w_hs, w_ok, w_orphan, len_err, addr_match;
  logic [WA-1:0] beat_addr;
  logic [31:0] hold_base, hold_new;
  logic        hit_base, hit_new;
  logic        b_hs, b_empty, b_full, b_push, b_pop, b_wr_en, b_ovf, b_bad;
  b_t          b_head;
  logic        tohost_hit, resp_err, wd_fire;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.AWADDR[1:0];

  // AW queue; an AW accepted this cycle is visible to the W side (bypass when empty).
  always_comb begin
    aw_hs      = bus.AWVALID & bus.AWREADY;
    aw_new     = '{id: bus.AWID, waddr: bus.AWADDR[ADDR_W-1:2], len: bus.AWLEN};
    aw_empty   = (aw_cnt_q == '0);
    aw_full    = (aw_cnt_q == CW'(QDEPTH));
    head       = aw_empty ? aw_new : aw_mem[aw_rd_q];
    head_valid = !aw_empty || aw_hs;
    w_hs       = bus.WVALID & bus.WREADY;
    w_ok       = w_hs & head_valid;
    w_orphan   = w_hs & !head_valid;
    aw_pop     = w_ok & bus.WLAST;
    aw_ovf     = aw_hs & aw_full & !aw_pop;
    aw_push    = aw_hs & !aw_ovf;
    aw_cnt_d   = aw_cnt_q + CW'(aw_push) - CW'(aw_pop);
  end

  // Beat tracking; hold/hit restart from zero on the first beat of each burst.
  always_comb begin
    beat_addr  = head.waddr + WA'(beat_q);
    addr_match = w_ok && (beat_addr == TOHOST_ADDR[ADDR_W-1:2]);
    hold_base  = (beat_q == 8'd0) ? 32'd0 : hold_q;
    hit_base   = (beat_q == 8'd0) ? 1'b0 : hit_q;
    for (int i = 0; i < 4; i++) begin
      hold_new[8*i +: 8] = (addr_match && bus.WSTRB[i]) ? bus.WDATA[8*i +: 8]
                                                         : hold_base[8*i +: 8];
    end
    hit_new = hit_base | addr_match;
    len_err = w_ok && (bus.WLAST ? (beat_q != head.len) : (beat_q >= head.len));
    beat_d  = beat_q;
    hold_d  = hold_q;
    hit_d   = hit_q;
    if (w_ok) begin
      beat_d = bus.WLAST ? 8'd0 : beat_q + 8'd1;
      hold_d = hold_new;
      hit_d  = hit_new;
    end
  end

  // B-pending queue; responses arrive in order and must match the head ID.
  always_comb begin
    b_hs     = bus.BVALID & bus.BREADY;
    b_empty  = (b_cnt_q == '0);
    b_full   = (b_cnt_q == CW'(QDEPTH));
    b_head   = b_mem[b_rd_q];
    b_pop    = b_hs && !b_empty && (bus.BID == b_head.id);
    b_bad    = b_hs & !b_pop;
    b_push   = aw_pop;
    b_ovf    = b_push & b_full & !b_pop;
    b_wr_en  = b_push & !b_ovf;
    b_cnt_d  = b_cnt_q + CW'(b_wr_en) - CW'(b_pop);
    resp_err = b_pop && b_head.hit && (bus.BRESP != 2'b00);
  end

  always_comb begin
    tohost_hit = b_pop && b_head.hit && (bus.BRESP == 2'b00) && (state_q == StRun);
    wd_fire    = (TIMEOUT != 0) && (state_q == StRun) && (cyc_q == TIMEOUT - 32'd1);
    we_d       = 1'b0;
    tohost_d   = tohost_q;
    timeout_d  = timeout_q;
    state_d    = state_q;
    cyc_d      = (state_q == StRun) ? cyc_q + 32'd1 : cyc_q;
    // A real tohost write takes priority over a coincident watchdog expiry.
    if (tohost_hit) begin
      we_d     = 1'b1;
      tohost_d = b_head.hold;
      state_d  = StDone;
    end else if (wd_fire) begin
      we_d      = 1'b1;
      tohost_d  = 32'hFFFF_FFFF;
      timeout_d = 1'b1;
      state_d   = StDone;
    end
    err_d = err_q | aw_ovf | w_orphan | len_err | b_ovf | b_bad | resp_err;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        aw_mem[i] <= '0;
        b_mem[i]  <= '0;
      end
      aw_wr_q   <= '0;
      aw_rd_q   <= '0;
      aw_cnt_q  <= '0;
      b_wr_q    <= '0;
      b_rd_q    <= '0;
      b_cnt_q   <= '0;
      beat_q    <= '0;
      hold_q    <= '0;
      hit_q     <= 1'b0;
      state_q   <= StRun;
      cyc_q     <= '0;
      we_q      <= 1'b0;
      tohost_q  <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (aw_push) begin
        aw_mem[aw_wr_q] <= aw_new;
        aw_wr_q         <= aw_wr_q + PW'(1);
      end
      if (aw_pop) aw_rd_q <= aw_rd_q + PW'(1);
      if (b_wr_en) begin
        b_mem[b_wr_q] <= '{id: head.id, hit: hit_new, hold: hold_new};
        b_wr_q        <= b_wr_q + PW'(1);
      end
      if (b_pop) b_rd_q <= b_rd_q + PW'(1);
      aw_cnt_q  <= aw_cnt_d;
      b_cnt_q   <= b_cnt_d;
      beat_q    <= beat_d;
      hold_q    <= hold_d;
      hit_q     <= hit_d;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      tohost_q  <= tohost_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign tohost_we   = we_q;
  assign tohost      = tohost_q;
  assign timeout_hit = timeout_q;
  assign err         = err_q;

endmodule
